// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the pipeline. It turns an EX/MEM memory
// operation into a single held request on the data-memory port and stalls
// upstream until the memory acknowledges it. It then loads the MEM/WB
// registers with the result, or with a fault for misaligned or ambiguous
// operations.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abandon a request after
// 16 consecutive un-acknowledged ACCESS cycles. The transaction then retires
// with fault=1.
//
// Memory handshake: dmemReq is the valid side and dmemAck is the ready side.
// Once dmemReq rises, dmemReq, dmemWe, dmemAddr and dmemWdata are frozen until
// the cycle in which dmemAck is high. That cycle completes the transfer, and
// dmemRdata is taken on its closing edge. dmemAck is ignored while no request
// is outstanding.
module mem_access_stage (
   input  logic        clk,
   input  logic        reset,
   // EX/MEM side
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  wbIn,
   input  logic [31:0] aluIn,
   input  logic [31:0] rd2In,
   input  logic [31:0] instrIn,
   // data memory
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWdata,
   input  logic        dmemAck,
   input  logic [31:0] dmemRdata,
   // pipeline control
   output logic        stall,
   // MEM/WB side
   output logic [1:0]  wbOut,
   output logic [31:0] readData,
   output logic [31:0] aluOut,
   output logic [4:0]  rdOut,
   output logic        fault,
   // observability: 1 while a request is outstanding
   output logic        dbgState
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t state;

   logic mem_any;      // some memory operation requested
   logic mem_one;      // exactly one of read/write requested
   logic aligned;      // word-aligned address
   logic issue;        // legal operation that will go to memory
   logic timeout_hit;  // request abandoned in this cycle

   // Only the destination register field of the instruction is carried on.
   logic unused_instr;
   assign unused_instr = &{1'b0, instrIn[31:12], instrIn[6:0]};

   assign mem_any  = memRead | memWrite;
   assign mem_one  = memRead ^ memWrite;
   assign aligned  = (aluIn[1:0] == 2'b00);
   assign issue    = mem_one & aligned;
   assign dbgState = (state == ACCESS);

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [3:0] to_cnt;

   // Count consecutive un-acknowledged ACCESS cycles; the count is zero in IDLE, so it starts clean on every entry to ACCESS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= 4'd0;
      end else if (state == IDLE) begin
         to_cnt <= 4'd0;
      end else if (!dmemAck) begin
         to_cnt <= to_cnt + 4'd1;
      end
   end

   // The 16th waiting cycle gives up unless the ack arrives in that same cycle.
   assign timeout_hit = (state == ACCESS) && !dmemAck && (to_cnt == 4'hF);
`else
   assign timeout_hit = 1'b0;
`endif

   // Hold upstream while a legal memory op is being issued or is waiting for its ack; never stall during reset.
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         if (state == IDLE) begin
            stall = issue;
         end else begin
            stall = ~dmemAck & ~timeout_hit;
         end
      end
   end

   // Stage FSM: issue requests, hold them until ack, and load the MEM/WB registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dmemReq   <= 1'b0;
         dmemWe    <= 1'b0;
         dmemAddr  <= 32'd0;
         dmemWdata <= 32'd0;
         wbOut     <= 2'b00;
         readData  <= 32'd0;
         aluOut    <= 32'd0;
         rdOut     <= 5'd0;
         fault     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  // Freeze the request; MEM/WB sees a bubble while we wait.
                  dmemReq   <= 1'b1;
                  dmemWe    <= memWrite;
                  dmemAddr  <= aluIn;
                  dmemWdata <= rd2In;
                  wbOut     <= 2'b00;
                  fault     <= 1'b0;
                  state     <= ACCESS;
               end else if (mem_any) begin
                  // Misaligned, or read and write together: retire as a fault without touching memory.
                  wbOut  <= 2'b00;
                  aluOut <= aluIn;
                  rdOut  <= instrIn[11:7];
                  fault  <= 1'b1;
               end else begin
                  // Plain ALU result passes straight through; readData keeps its value.
                  wbOut  <= wbIn;
                  aluOut <= aluIn;
                  rdOut  <= instrIn[11:7];
                  fault  <= 1'b0;
               end
            end
            ACCESS: begin
               if (dmemAck) begin
                  // The op type is taken from the registered write enable, not the live input.
                  if (!dmemWe) begin
                     readData <= dmemRdata;
                  end
                  wbOut   <= wbIn;
                  aluOut  <= aluIn;
                  rdOut   <= instrIn[11:7];
                  fault   <= 1'b0;
                  dmemReq <= 1'b0;
                  dmemWe  <= 1'b0;
                  state   <= IDLE;
               end else if (timeout_hit) begin
                  wbOut   <= 2'b00;
                  aluOut  <= aluIn;
                  rdOut   <= instrIn[11:7];
                  fault   <= 1'b1;
                  dmemReq <= 1'b0;
                  dmemWe  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  wbOut <= 2'b00;
                  fault <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               dmemReq <= 1'b0;
               dmemWe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; single clock domain.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have EX/MEM-side inputs: memRead in 1, memWrite in 1, wbIn in 2, aluIn in 32 (address/result), rd2In in 32 (store data), instrIn in 32.
REQ-004 SHALL have data-memory ports: dmemReq out 1, dmemWe out 1, dmemAddr out 32, dmemWdata out 32, dmemAck in 1, dmemRdata in 32.
REQ-005 SHALL have stall out 1: high means upstream holds EX/MEM inputs stable.
REQ-006 SHALL have MEM/WB-side outputs: wbOut out 2, readData out 32, aluOut out 32, rdOut out 5 (= instrIn[11:7]), fault out 1.

Function
REQ-007 SHALL implement FSM states IDLE and ACCESS; reset state IDLE.
REQ-008 IDLE, memRead=memWrite=0: stall=0; MEM/WB regs load wbIn, aluIn, instrIn[11:7], fault=0 next edge; readData holds its value; latency 1 cycle.
REQ-009 IDLE, exactly one of memRead/memWrite=1, aluIn[1:0]=00: stall=1 combinationally; next edge registers dmemAddr=aluIn, dmemWdata=rd2In, dmemWe=memWrite, sets dmemReq=1, enters ACCESS; MEM/WB loads bubble (wbOut=0, fault=0).
REQ-010 IDLE, memory op with aluIn[1:0]!=00, or memRead=memWrite=1: no request issued; stall=0; next edge MEM/WB loads fault=1, wbOut=0, aluOut=aluIn, rdOut=instrIn[11:7].
REQ-011 ACCESS: dmemReq, dmemWe, dmemAddr, dmemWdata SHALL stay constant until ack; stall = ~dmemAck (combinational).
REQ-012 ACCESS with dmemAck=1: on that edge readData<=dmemRdata if read (unchanged if write), wbOut<=wbIn, aluOut<=aluIn, rdOut<=instrIn[11:7], fault<=0, dmemReq<=0, state IDLE.
REQ-013 ACCESS with dmemAck=0: MEM/WB loads bubble (wbOut=0, fault=0) each edge.
REQ-014 dmemAck SHALL be ignored in IDLE; no MEM/WB side effect.
REQ-015 Minimum memory-op latency SHALL be 2 cycles (issue cycle + ack cycle); back-to-back memory ops SHALL issue dmemReq for the second op no earlier than 1 cycle after the first ack.
REQ-016 All outputs except stall SHALL be registered; stall SHALL depend only on state, memRead, memWrite, aluIn[1:0], dmemAck.

Reset
REQ-017 reset=0 SHALL immediately (asynchronously) force state IDLE, dmemReq=0, dmemWe=0, dmemAddr=0, dmemWdata=0, wbOut=0, readData=0, aluOut=0, rdOut=0, fault=0, timeout counter=0.
REQ-018 reset asserted mid-ACCESS SHALL abandon the transaction; no readData update; first cycle after release SHALL be IDLE.
REQ-019 stall SHALL be 0 while reset=0.

Configuration
REQ-020 Macro MEM_ACCESS_TIMEOUT_EN defined: 4-bit counter clears on entry to ACCESS and increments each ACCESS cycle with dmemAck=0.
REQ-021 With MEM_ACCESS_TIMEOUT_EN, the 16th consecutive ACCESS cycle without ack SHALL drive stall=0 in that cycle and on its edge set dmemReq=0, state IDLE, fault=1, wbOut=0, aluOut=aluIn, rdOut=instrIn[11:7]; ack in that same cycle SHALL take priority as a normal completion.
REQ-022 Without MEM_ACCESS_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for dmemAck.

Verification
REQ-023 Non-memory op wbIn=2'b10, aluIn=0x0000_0040, instrIn[11:7]=5 -> next cycle wbOut=10, aluOut=0x40, rdOut=5, stall=0 throughout.
REQ-024 Load aluIn=0x100, dmemAck 3 cycles after dmemReq rises, dmemRdata=0xDEADBEEF -> stall high 4 cycles, dmemAddr=0x100, dmemWe=0, readData=0xDEADBEEF, wbOut=wbIn after ack edge.
REQ-025 Store aluIn=0x204, rd2In=0x12345678, ack on first ACCESS cycle -> dmemWe=1, dmemWdata=0x12345678 for one cycle, readData unchanged, 2-cycle latency.
REQ-026 Load aluIn=0x102 -> dmemReq never rises, stall=0, next cycle fault=1, wbOut=0.
REQ-027 Load, reset pulled low in 2nd ACCESS cycle -> dmemReq=0 immediately, all outputs 0, IDLE after release, later ack ignored.
REQ-028 MEM_ACCESS_TIMEOUT_EN defined, store never acked -> after 16 ACCESS cycles dmemReq=0, fault=1, stall=0; undefined build -> stall remains 1 at cycle 100.
